// File: rtl/neuron_mac_z_pkg.sv
// Shared Q4.4 format constants, saturation bounds and MAC sequencing states
// for the neuron layer blocks.
package neuron_mac_z_pkg;

    localparam int DATA_W = 8;
    localparam int FRAC_W = 4;

    localparam int SAT_MAX = (2 ** (DATA_W - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (DATA_W - 1));

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACC    = 2'd1,
        S_FINISH = 2'd2,
        S_OUT    = 2'd3
    } mac_state_e;

endpackage : neuron_mac_z_pkg

// File: rtl/neuron_mac_z_fixed_round_sat.sv
// Combinational narrowing of a wide signed accumulator: arithmetic right shift
// (floor) followed by a clamp to the signed OUT_W range.
module fixed_round_sat #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o
);

    localparam logic signed [IN_W-1:0] MAX_V =
        {{(IN_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V =
        {{(IN_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [IN_W-1:0] shifted;

    assign shifted = din_i >>> SHIFT;

    always_comb begin
        dout_o = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            dout_o = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            dout_o = MIN_V[OUT_W-1:0];
        end
    end

endmodule : fixed_round_sat

// File: rtl/neuron_mac_z.sv
// Serial multiply-accumulate for one neuron: z = sat(sum(x*w) + bias) in Q4.4,
// delivered over a valid/ready handshake to the activation stage.
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for start; bias latched and acc cleared on start
// ACC    | in_ready high, one x/w product accumulated per handshake
// FINISH | add bias, shift and saturate, register z_value
// OUT    | z_valid held with stable z_value until z_ready
module neuron_mac_z #(
    parameter int N_INPUTS = 2,
    parameter int DATA_W   = neuron_mac_z_pkg::DATA_W,
    parameter int FRAC_W   = neuron_mac_z_pkg::FRAC_W,
    parameter int ACC_W    = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_data,
    input  logic signed [DATA_W-1:0] w_data,
    output logic                     z_valid,
    input  logic                     z_ready,
    output logic signed [DATA_W-1:0] z_value,
    output logic                     busy
);

    import neuron_mac_z_pkg::*;

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);

    mac_state_e               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic signed [DATA_W-1:0] bias_q, bias_d;
    logic signed [DATA_W-1:0] z_value_q, z_value_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum_biased;
    logic signed [DATA_W-1:0] z_sat;

    assign prod     = x_data * w_data;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Bias is Q4.4 while the product sum is Q8.8, so align it up by FRAC_W.
    assign bias_ext   = {{(ACC_W - DATA_W - FRAC_W){bias_q[DATA_W-1]}}, bias_q, {FRAC_W{1'b0}}};
    assign sum_biased = acc_q + bias_ext;

    fixed_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W),
        .SHIFT (FRAC_W)
    ) u_round_sat (
        .din_i  (sum_biased),
        .dout_o (z_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            bias_q    <= '0;
            z_value_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            bias_q    <= bias_d;
            z_value_q <= z_value_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        bias_d    = bias_q;
        z_value_d = z_value_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    bias_d  = bias;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d   = acc_q + prod_ext;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                z_value_d = z_sat;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (z_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready = (state_q == S_ACC);
    assign z_valid  = (state_q == S_OUT);
    assign busy     = (state_q != S_IDLE);
    assign z_value  = z_value_q;

endmodule : neuron_mac_z

// File: tb/tb_neuron_mac_z.sv
// Directed bench for neuron_mac_z: hand-computed Q4.4 results, latency,
// backpressure, ignored start, input gaps and asynchronous reset abort.
module tb_neuron_mac_z;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] bias;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_data;
    logic [7:0] w_data;
    logic       z_valid;
    logic       z_ready;
    logic [7:0] z_value;
    logic       busy;

    int n_checks;
    int n_errors;

    neuron_mac_z #(
        .N_INPUTS (2),
        .DATA_W   (8),
        .FRAC_W   (4),
        .ACC_W    (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bias     (bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_data   (x_data),
        .w_data   (w_data),
        .z_valid  (z_valid),
        .z_ready  (z_ready),
        .z_value  (z_value),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_eval(input logic [7:0] b,
                            input logic [7:0] x0, input logic [7:0] w0,
                            input logic [7:0] x1, input logic [7:0] w1,
                            input int gap, output int lat);
        int cyc;
        start = 1'b1;
        bias  = b;
        @(negedge clk);
        cyc   = 1;
        start = 1'b0;
        bias  = 8'h00;
        check("ready_after_start", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        x_data   = x0;
        w_data   = w0;
        @(negedge clk);
        cyc++;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            check("ready_in_gap", {31'd0, in_ready}, 32'd1);
            check("no_early_valid", {31'd0, z_valid}, 32'd0);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b1;
        x_data   = x1;
        w_data   = w1;
        @(negedge clk);
        cyc++;
        in_valid = 1'b0;
        x_data   = 8'h00;
        w_data   = 8'h00;
        check("finish_not_ready", {31'd0, in_ready}, 32'd0);
        while (!z_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!z_valid) check("z_valid_timeout", {31'd0, z_valid}, 32'd1);
        lat = cyc;
    endtask

    task automatic accept_result();
        z_ready = 1'b1;
        @(negedge clk);
        z_ready = 1'b0;
        check("valid_drop", {31'd0, z_valid}, 32'd0);
        check("idle_after_hs", {31'd0, busy}, 32'd0);
    endtask

    int lat;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        start    = 1'b0;
        bias     = 8'h00;
        in_valid = 1'b0;
        x_data   = 8'h00;
        w_data   = 8'h00;
        z_ready  = 1'b0;

        #12;
        check("rst_z_value", {24'd0, z_value}, 32'h00);
        check("rst_z_valid", {31'd0, z_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1.0*1.0 + 1.0*1.0 = 2.0
        run_eval(8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 0, lat);
        check("s1_z", {24'd0, z_value}, 32'h20);
        check("s1_latency", lat, 32'd4);
        accept_result();

        // (127*127*2 + 127*16) >> 4 = 2143 -> 127
        run_eval(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 0, lat);
        check("pos_sat", {24'd0, z_value}, 32'h7F);
        accept_result();

        // (-128*127*2 - 128*16) >> 4 = -2160 -> -128
        run_eval(8'h80, 8'h80, 8'h7F, 8'h80, 8'h7F, 0, lat);
        check("neg_sat", {24'd0, z_value}, 32'h80);
        accept_result();

        // 2 >> 4 = 0
        run_eval(8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 0, lat);
        check("small_pos", {24'd0, z_value}, 32'h00);
        accept_result();

        // -2 >>> 4 = -1 (floor)
        run_eval(8'h00, 8'h01, 8'hFF, 8'h01, 8'hFF, 0, lat);
        check("floor_neg", {24'd0, z_value}, 32'hFF);
        accept_result();

        // Backpressure with a start pulse during OUT
        run_eval(8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 0, lat);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clk);
            check("bp_valid", {31'd0, z_valid}, 32'd1);
            check("bp_value", {24'd0, z_value}, 32'h20);
            check("bp_busy", {31'd0, busy}, 32'd1);
        end
        // Start coinciding with the handshake is also dropped.
        start   = 1'b1;
        z_ready = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        z_ready = 1'b0;
        check("hs_valid_drop", {31'd0, z_valid}, 32'd0);
        check("hs_start_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("still_idle", {31'd0, busy}, 32'd0);
        check("z_value_kept", {24'd0, z_value}, 32'h20);

        // Three idle cycles between pairs
        run_eval(8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 3, lat);
        check("gap_z", {24'd0, z_value}, 32'h20);
        check("gap_latency", lat, 32'd7);
        accept_result();

        // Mixed-sign value with bias: 1.5*2.0 + (-0.5)*1.0 + 0.25 = 2.75 -> 0x2C
        run_eval(8'h04, 8'h18, 8'h20, 8'hF8, 8'h10, 1, lat);
        check("mixed_z", {24'd0, z_value}, 32'h2C);
        accept_result();

        // Asynchronous reset after the first pair is accepted
        start = 1'b1;
        bias  = 8'h7F;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        x_data   = 8'h7F;
        w_data   = 8'h7F;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_z_value", {24'd0, z_value}, 32'h00);
        check("arst_z_valid", {31'd0, z_valid}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("no_partial_out", {31'd0, z_valid}, 32'd0);
        run_eval(8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 0, lat);
        check("post_rst_z", {24'd0, z_value}, 32'h20);
        accept_result();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_neuron_mac_z

// File: doc/neuron_mac_z.md
Name: neuron_mac_z

Overview:
Sequential multiply-accumulate stage that computes one neuron's pre-activation value z = sum(x_i * w_i) + bias in Q4.4 fixed point. It consumes N_INPUTS input/weight pairs serially, saturates the result to 8-bit signed, and presents z_value to the downstream LUT/interpolator activation stage. It sits directly upstream of the layer activation function and drives its 8-bit signed z_value input.

Parameters:
N_INPUTS, 2, number of x/w pairs accumulated per neuron evaluation (>=1)
DATA_W, 8, width of x, w, bias and z_value (signed)
FRAC_W, 4, fractional bits of all DATA_W operands (Q4.4)
ACC_W, 20, accumulator width (signed); must be >= 2*DATA_W + clog2(N_INPUTS) + 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle request to begin an evaluation; sampled only in IDLE
bias  in  DATA_W  signed Q4.4 bias, latched on accepted start
in_valid  in  1  x_data/w_data pair valid
in_ready  out  1  block accepts a pair this cycle
x_data  in  DATA_W  signed Q4.4 input activation
w_data  in  DATA_W  signed Q4.4 weight
z_valid  out  1  z_value valid, held until accepted
z_ready  in  1  downstream accepts z_value
z_value  out  DATA_W  signed Q4.4 saturated pre-activation
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acc=0, count=0, bias register=0, z_value=0, z_valid=0, in_ready=0, busy=0. Reset asserted mid-evaluation abandons it; no partial result is ever emitted.
- FSM states: IDLE, ACC, FINISH, OUT.
- IDLE: start=1 -> latch bias, acc=0, count=0, go to ACC on the next cycle. start in any other state is ignored (no queueing).
- ACC: in_ready=1. On in_valid&in_ready: acc += sext(x_data*w_data) (full 2*DATA_W signed product, Q8.8), count++. The pair accepted when count==N_INPUTS-1 moves the FSM to FINISH. in_valid=0 stalls indefinitely with no state change.
- FINISH (exactly one cycle, in_ready=0): s = acc + (sext(bias) << FRAC_W); t = s >>> FRAC_W (arithmetic shift, truncation toward -inf); z_value = clamp(t, -2^(DATA_W-1), 2^(DATA_W-1)-1). Register z_value, set z_valid=1, go to OUT.
- OUT: z_valid=1 and z_value held stable until z_ready=1; on handshake z_valid=0 -> IDLE. A start in the same cycle as the OUT handshake is ignored; start is sampled again from the following IDLE cycle.
- Latency: start -> first in_ready is 1 cycle; the last accepted pair -> z_valid is 1 cycle (FINISH). Minimum evaluation with no stalls is N_INPUTS+2 cycles from start to z_valid.
- z_value keeps its last value after the handshake; only z_valid qualifies it.
- The accumulator never overflows for legal ACC_W; saturation occurs only at the final narrowing.

Decomposition:
- Shared package: the Q-format constants (DATA_W, FRAC_W), the saturation bounds (SAT_MAX=127, SAT_MIN=-128), and the FSM state enum (IDLE/ACC/FINISH/OUT) so that later layer-sequencer blocks reuse them.
- One natural sub-module: fixed_round_sat, a combinational ACC_W->DATA_W arithmetic shift plus clamp, reused by other layers' MAC stages. The multiply and accumulate stay inline.

Test Plan:
1. bias=0x00; pairs (x=0x10, w=0x10), (0x10, 0x10), i.e. 1.0*1.0 twice -> z_value=0x20 (2.0); z_valid 1 cycle after the 2nd pair; total 4 cycles from start with no stalls.
2. bias=0x7F; pairs (0x7F, 0x7F) x2 -> positive saturation, z_value=0x7F. Pairs (0x80, 0x7F) x2 with bias=0x80 -> z_value=0x80.
3. bias=0x00; pairs (0x01, 0x01) x2 -> z_value=0x00. Pairs (0x01, 0xFF) x2 -> z_value=0xFF (floor truncation check).
4. Backpressure: produce a result of 0x20, hold z_ready=0 for 5 cycles -> z_valid and z_value stay stable. Pulse start during OUT -> ignored, busy stays 1. z_ready=1 -> z_valid drops and the FSM is IDLE.
5. in_valid gaps: insert 3 idle cycles between the pairs of scenario 1 -> same z_value=0x20, in_ready held high throughout ACC.
6. Assert rst=0 asynchronously after the first pair is accepted -> all outputs return to 0 immediately. A fresh start with scenario 1 data then yields 0x20, with no residue from the aborted accumulation.
